// File: rtl/uart_arb_wb8_pkg.sv
// uart_arb_wb8_pkg
// Shared definitions for the UART arbiter slice:
//   - uart_wb8 register addresses (data, rx status, tx status)
//   - arbiter FSM state encoding
//   - round-robin slot identifiers and the slot-rotation helper
package uart_arb_wb8_pkg;

    localparam logic [1:0] UART_ADR_DATA    = 2'd0; // wr: TX byte, rd: RX byte (clears RX available)
    localparam logic [1:0] UART_ADR_RX_STAT = 2'd1; // rd bit0: RX byte available
    localparam logic [1:0] UART_ADR_TX_STAT = 2'd2; // rd bit0: transmitter idle

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_POLL  = 3'd1,
        ST_TX_WRITE = 3'd2,
        ST_RX_POLL  = 3'd3,
        ST_RX_READ  = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        SLOT_REQ0 = 2'd0,
        SLOT_REQ1 = 2'd1,
        SLOT_RX   = 2'd2
    } slot_t;

    // Slot that follows s in the round-robin ring. Without the RX path the
    // ring is just req0 -> req1 -> req0.
    function automatic slot_t next_slot(input slot_t s, input logic rx_en);
        slot_t n;
        case (s)
            SLOT_REQ0: n = SLOT_REQ1;
            SLOT_REQ1: n = rx_en ? SLOT_RX : SLOT_REQ0;
            default:   n = SLOT_REQ0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_arb_wbm.sv
// uart_arb_wbm
// Single-access Wishbone master with ack timeout.
//   clk, rst_n            clock, async active-low reset
//   start                 begin an access with cmd_adr/cmd_we/cmd_dat (ignored while busy)
//   cmd_adr/cmd_we/cmd_dat access description, captured when the strobe rises
//   done                  access acknowledged this cycle (rdata valid this cycle)
//   abort                 access timed out this cycle
//   rdata                 read data, valid with done
//   busy                  strobe is up
//   wb_adr/wb_dat/wb_stb/wb_we  bus outputs
//   wb_rdat/wb_ack        bus inputs
// The strobe stays up with stable adr/we/dat until the ack cycle or until it
// has been up ACK_TIMEOUT cycles; an ack in that final cycle still wins.
module uart_arb_wbm #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd_adr,
    input  logic       cmd_we,
    input  logic [7:0] cmd_dat,
    output logic       done,
    output logic       abort,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [1:0] wb_adr,
    output logic [7:0] wb_dat,
    output logic       wb_stb,
    output logic       wb_we,
    input  logic [7:0] wb_rdat,
    input  logic       wb_ack
);

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    // Cycles the strobe has already been up without ack.
    logic [7:0] timer;

    assign done  = wb_stb & wb_ack;
    assign abort = wb_stb & ~wb_ack & (timer == TIMER_LAST);
    assign rdata = wb_rdat;
    assign busy  = wb_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            wb_adr <= 2'd0;
            wb_dat <= 8'd0;
            timer  <= 8'd0;
        end else if (wb_stb) begin
            if (done || abort) begin
                wb_stb <= 1'b0;
                wb_we  <= 1'b0;
            end else begin
                timer <= timer + 8'd1;
            end
        end else if (start) begin
            wb_stb <= 1'b1;
            wb_we  <= cmd_we;
            wb_adr <= cmd_adr;
            wb_dat <= cmd_dat;
            timer  <= 8'd0;
        end
    end

endmodule

// File: rtl/uart_arb_wb8.sv
// uart_arb_wb8
// Round-robin arbiter sharing one uart_wb8 (Wishbone, 8-bit) between two TX
// requesters and an RX consumer.
//   I_wb_clk, I_wb_rst_n          clock, async active-low reset
//   I_reqK_valid/I_reqK_data      TX byte offered by requester K (K = 0, 1)
//   O_reqK_ready                  one-cycle pulse: requester K's byte taken
//   O_rx_valid/O_rx_data          RX byte held for the consumer
//   I_rx_ready                    consumer takes the held RX byte
//   O_uart_adr/dat/stb/we         Wishbone master outputs
//   I_uart_dat/I_uart_ack         Wishbone master inputs
//   O_timeout                     sticky: some access went unacknowledged
// Build option: define UART_ARB_RX_EN to include the RX path (RX_POLL/RX_READ
// and the rx arbitration slot). Without it O_rx_valid/O_rx_data are 0.
//
// Handshakes: a requester holds valid and data steady until it sees ready=1;
// ready is a registered one-cycle pulse in the cycle after the grant edge, and
// the byte latched at the grant edge is the one held during that ready cycle.
// The RX side holds O_rx_valid and O_rx_data until a cycle with I_rx_ready=1.
module uart_arb_wb8
    import uart_arb_wb8_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       I_wb_clk,
    input  logic       I_wb_rst_n,
    input  logic       I_req0_valid,
    input  logic [7:0] I_req0_data,
    output logic       O_req0_ready,
    input  logic       I_req1_valid,
    input  logic [7:0] I_req1_data,
    output logic       O_req1_ready,
    output logic       O_rx_valid,
    output logic [7:0] O_rx_data,
    input  logic       I_rx_ready,
    output logic [1:0] O_uart_adr,
    output logic [7:0] O_uart_dat,
    output logic       O_uart_stb,
    output logic       O_uart_we,
    input  logic [7:0] I_uart_dat,
    input  logic       I_uart_ack,
    output logic       O_timeout
);

`ifdef UART_ARB_RX_EN
    localparam logic RX_EN = 1'b1;
`else
    localparam logic RX_EN = 1'b0;
`endif

    arb_state_t state, state_nxt;
    slot_t      last_grant, last_nxt;
    slot_t      cand1, cand2, cand3, grant_slot;
    logic       grant_valid;
    logic [3:0] elig;

    logic       grant0, grant1;
    logic       req0_ready_q, req1_ready_q;
    logic [7:0] tx_byte;
    logic       timeout_q;

    logic       start, done, abort, busy;
    logic [1:0] cmd_adr;
    logic       cmd_we;
    logic [7:0] cmd_dat;
    logic [7:0] rdata;

`ifdef UART_ARB_RX_EN
    logic       rx_load;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
`endif

    uart_arb_wbm #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wbm (
        .clk     (I_wb_clk),
        .rst_n   (I_wb_rst_n),
        .start   (start),
        .cmd_adr (cmd_adr),
        .cmd_we  (cmd_we),
        .cmd_dat (cmd_dat),
        .done    (done),
        .abort   (abort),
        .rdata   (rdata),
        .busy    (busy),
        .wb_adr  (O_uart_adr),
        .wb_dat  (O_uart_dat),
        .wb_stb  (O_uart_stb),
        .wb_we   (O_uart_we),
        .wb_rdat (I_uart_dat),
        .wb_ack  (I_uart_ack)
    );

    // Round-robin search starting at the slot after the last grant. The rx
    // slot only competes while no RX byte is waiting for the consumer.
    always_comb begin
        elig        = {1'b0, RX_EN & ~O_rx_valid, I_req1_valid, I_req0_valid};
        cand1       = next_slot(last_grant, RX_EN);
        cand2       = next_slot(cand1, RX_EN);
        cand3       = next_slot(cand2, RX_EN);
        grant_valid = 1'b1;
        grant_slot  = cand1;
        if (elig[cand1]) begin
            grant_slot = cand1;
        end else if (elig[cand2]) begin
            grant_slot = cand2;
        end else if (elig[cand3]) begin
            grant_slot = cand3;
        end else begin
            grant_valid = 1'b0;
        end
    end

    // Next-state and bus command. Each access state re-issues start whenever
    // the engine is idle, so a repeated poll gets its one-cycle strobe gap
    // for free.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        start     = 1'b0;
        cmd_adr   = UART_ADR_TX_STAT;
        cmd_we    = 1'b0;
        cmd_dat   = tx_byte;
        grant0    = 1'b0;
        grant1    = 1'b0;
`ifdef UART_ARB_RX_EN
        rx_load   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    last_nxt = grant_slot;
                    case (grant_slot)
                        SLOT_REQ0: begin
                            grant0    = 1'b1;
                            state_nxt = ST_TX_POLL;
                        end
                        SLOT_REQ1: begin
                            grant1    = 1'b1;
                            state_nxt = ST_TX_POLL;
                        end
                        default: begin
`ifdef UART_ARB_RX_EN
                            state_nxt = ST_RX_POLL;
`else
                            state_nxt = ST_IDLE;
`endif
                        end
                    endcase
                end
            end
            ST_TX_POLL: begin
                cmd_adr = UART_ADR_TX_STAT;
                start   = ~busy;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (done) begin
                    state_nxt = rdata[0] ? ST_TX_WRITE : ST_TX_POLL;
                end
            end
            ST_TX_WRITE: begin
                cmd_adr = UART_ADR_DATA;
                cmd_we  = 1'b1;
                start   = ~busy;
                if (done || abort) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef UART_ARB_RX_EN
            ST_RX_POLL: begin
                cmd_adr = UART_ADR_RX_STAT;
                start   = ~busy;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (done) begin
                    state_nxt = rdata[0] ? ST_RX_READ : ST_IDLE;
                end
            end
            ST_RX_READ: begin
                cmd_adr = UART_ADR_DATA;
                start   = ~busy;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (done) begin
                    rx_load   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_wb_clk or negedge I_wb_rst_n) begin
        if (!I_wb_rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= SLOT_RX;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            tx_byte      <= 8'd0;
            timeout_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_nxt;
            req0_ready_q <= grant0;
            req1_ready_q <= grant1;
            if (grant0) begin
                tx_byte <= I_req0_data;
            end else if (grant1) begin
                tx_byte <= I_req1_data;
            end else if (abort) begin
                tx_byte <= 8'd0; // timed-out byte is dropped
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef UART_ARB_RX_EN
    always_ff @(posedge I_wb_clk or negedge I_wb_rst_n) begin
        if (!I_wb_rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
        end else if (rx_load) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rdata;
        end else if (rx_valid_q && I_rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign O_rx_valid = rx_valid_q;
    assign O_rx_data  = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx  = ^{I_rx_ready, rdata[7:1]};
    assign O_rx_valid = 1'b0;
    assign O_rx_data  = 8'd0;
`endif

    assign O_req0_ready = req0_ready_q;
    assign O_req1_ready = req1_ready_q;
    assign O_timeout    = timeout_q;

endmodule

// File: doc/uart_arb_wb8.md
UART_ARB_WB8 -- requirements
Module: uart_arb_wb8

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, range 1..255: cycles a Wishbone strobe may wait for ack before abort.
REQ-002 SHALL have ports, clock and reset first:
  I_wb_clk  in  1  sole clock, all logic on rising edge
  I_wb_rst_n  in  1  reset, asynchronous, active-low
  I_req0_valid  in  1  requester 0 has a TX byte
  I_req0_data  in  8  requester 0 TX byte
  O_req0_ready  out  1  requester 0 byte accepted this cycle
  I_req1_valid / I_req1_data / O_req1_ready  in/in/out  1/8/1  same for requester 1
  O_rx_valid  out  1  RX byte held for consumer
  O_rx_data  out  8  RX byte
  I_rx_ready  in  1  consumer takes RX byte
  O_uart_adr  out  2  Wishbone address to uart_wb8
  O_uart_dat  out  8  Wishbone write data
  O_uart_stb  out  1  Wishbone strobe
  O_uart_we  out  1  Wishbone write enable
  I_uart_dat  in  8  Wishbone read data
  I_uart_ack  in  1  Wishbone acknowledge
  O_timeout  out  1  sticky ack-timeout flag
REQ-003 UART register map SHALL be: adr 0 write = TX byte, read = RX byte (read clears RX-available); adr 1 read bit0 = RX available; adr 2 read bit0 = TX idle.

Function
REQ-004 SHALL be an FSM with states IDLE, TX_POLL, TX_WRITE, RX_POLL, RX_READ.
REQ-005 Each bus access SHALL raise O_uart_stb with stable adr/we/dat until the cycle I_uart_ack=1, drop stb the next cycle, and hold stb low at least one cycle between accesses.
REQ-006 In IDLE, arbitration SHALL be round-robin over slots {req0, req1, rx}, searching from the slot after the last granted one; rx eligible only when O_rx_valid=0.
REQ-007 Granting reqK SHALL latch I_reqK_data, pulse O_reqK_ready exactly one cycle, enter TX_POLL.
REQ-008 TX_POLL SHALL read adr 2; bit0=0 -> repeat TX_POLL; bit0=1 -> TX_WRITE.
REQ-009 TX_WRITE SHALL write the latched byte to adr 0 with we=1, then IDLE.
REQ-010 RX_POLL SHALL read adr 1; bit0=0 -> IDLE; bit0=1 -> RX_READ.
REQ-011 RX_READ SHALL read adr 0, load O_rx_data, set O_rx_valid, then IDLE.
REQ-012 O_rx_valid SHALL stay 1 with O_rx_data stable until a cycle with I_rx_ready=1, clearing next cycle; TX traffic continues meanwhile.
REQ-013 Both requesters valid with no prior grant: req0 first, then req1.
REQ-014 Ack timer SHALL clear at each strobe start; when it reaches ACK_TIMEOUT without ack: drop stb, set O_timeout, go IDLE, discard any latched TX byte.
REQ-015 O_timeout SHALL remain 1 until reset.
REQ-016 Ack arriving the same cycle the timer reaches ACK_TIMEOUT SHALL count as success.

Reset
REQ-017 I_wb_rst_n=0 SHALL asynchronously force IDLE, last-grant = rx, all outputs 0 (stb, we, ready pulses, O_rx_valid, O_timeout, adr, dat).
REQ-018 Reset mid-access SHALL drop stb immediately; latched TX byte and held RX byte are lost.

Configuration
REQ-019 Macro UART_ARB_RX_EN defined: RX path present as specified.
REQ-020 Macro undefined: RX_POLL/RX_READ absent, rx slot never eligible, O_rx_valid and O_rx_data tied 0, round-robin over req0/req1 only.

Structure
REQ-021 Shared package SHALL hold UART register addresses (data 0, rx status 1, tx status 2), state encoding, slot identifiers.
REQ-022 Wishbone single-access engine (strobe, ack wait, timeout) SHALL be sub-module uart_arb_wbm; arbiter/FSM stays in uart_arb_wb8.

Verification
REQ-023 req0 valid 0x54, slave acks after 2 cycles, adr2 reads 0x01 -> one ready pulse, write adr0 dat 0x54 we=1, back to IDLE.
REQ-024 req0 0x41 and req1 0x42 held continuously -> writes alternate 0x41,0x42,0x41 (RX_EN off) or interleaved with adr1 polls (RX_EN on).
REQ-025 adr2 reads 0x00 three times then 0x01 -> exactly four adr2 reads then one adr0 write.
REQ-026 RX_EN on, adr1=0x01, adr0=0x5A, I_rx_ready=0 -> O_rx_valid=1, data 0x5A stable; no further adr1 polls until I_rx_ready=1.
REQ-027 ACK_TIMEOUT=4, slave never acks -> stb low after 4 cycles, O_timeout=1 sticky, next request served normally.
REQ-028 I_wb_rst_n low during TX_POLL strobe -> stb and all outputs 0 without a clock edge.
